// File: rtl/ddr_mem_responder_pkg.sv
// Shared constants and types for the DDR memory responder.
package ddr_pkg;

  localparam int          DDR_ADDR_W   = 16;
  localparam int          DDR_DATA_W   = 32;
  localparam logic [31:0] DDR_ERR_DATA = 32'hDEADBEEF;

  // ACTIVE accepts requests; REFRESH blocks new requests while reads drain.
  typedef enum logic [0:0] {
    ACTIVE  = 1'b0,
    REFRESH = 1'b1
  } ddr_state_t;

endpackage

// File: rtl/ddr_rd_pipe.sv
// Fixed-latency read return line: {valid, err, data} shift one stage per cycle.
module ddr_rd_pipe #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q [DEPTH];
  logic              err_q   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  // Advance every stage each cycle; flush empties the line so flushed reads never return.
  // Empty slots carry zero data so the output bus reads 0 between returns.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        err_q[i]   <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & in_err;
      data_q[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/ddr_mem_responder.sv
// Memory-side responder for the DDR request bus: single-word reads/writes,
// fixed-latency in-order read returns, and periodic refresh stalls.
//
// Handshake: a request is taken at a rising edge when (ddr_rd_req | ddr_wr_req)
// and ddr_ready are both high; ddr_ready is a register, stable for the whole
// cycle. Returns (ddr_rd_valid, ddr_wr_done, ddr_err) are one-cycle strobes
// with no backpressure; the requester must always take them.
module ddr_mem_responder
  import ddr_pkg::*;
#(
  parameter int ADDR_W          = DDR_ADDR_W,
  parameter int DATA_W          = DDR_DATA_W,
  parameter int MEM_WORDS       = 16384,
  parameter int RD_LATENCY      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int REFRESH_PERIOD  = 1000,
  parameter int REFRESH_CYCLES  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ddr_rd_req,
  input  logic                ddr_wr_req,
  input  logic [ADDR_W-1:0]   ddr_addr,
  input  logic [DATA_W-1:0]   ddr_wr_data,
  input  logic [DATA_W/8-1:0] ddr_wr_be,
  output logic                ddr_ready,
  output logic                ddr_rd_valid,
  output logic [DATA_W-1:0]   ddr_rd_data,
  output logic                ddr_wr_done,
  output logic                ddr_err,
  output ddr_state_t          dbg_state
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int REF_W = $clog2(REFRESH_PERIOD);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Plain unpacked array so benches can preload program images into it.
  logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

  ddr_state_t        state, state_next;
  logic [REF_W-1:0]  ref_cnt, ref_next;
  logic [CNT_W-1:0]  out_cnt, cnt_next;
  logic              err_q;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              acc_rd, acc_wr;
  logic [DATA_W-1:0] rd_word;
  logic              pipe_err;

  assign in_range = (32'(ddr_addr) < 32'(MEM_WORDS));
  assign idx      = ddr_addr[IDX_W-1:0];

  // A write wins over a simultaneous read; the read is dropped and flagged.
  assign acc_wr  = ddr_wr_req & ddr_ready;
  assign acc_rd  = ddr_rd_req & ~ddr_wr_req & ddr_ready;
  assign rd_word = in_range ? mem[idx] : DATA_W'(DDR_ERR_DATA);

  // The refresh counter free-runs so windows start every REFRESH_PERIOD cycles;
  // it restarts at window entry and the window ends after REFRESH_CYCLES.
  always_comb begin
    state_next = state;
    ref_next   = ref_cnt + 1'b1;
    if (state == ACTIVE) begin
      if (ref_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
        state_next = REFRESH;
        ref_next   = '0;
      end
    end else if (ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
      state_next = ACTIVE;
    end
    cnt_next = out_cnt + CNT_W'(acc_rd) - CNT_W'(ddr_rd_valid);
  end

  // Control registers; ready is computed from next-cycle state and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACTIVE;
      ref_cnt     <= '0;
      out_cnt     <= '0;
      ddr_ready   <= 1'b0;
      ddr_wr_done <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_next;
      ref_cnt     <= ref_next;
      out_cnt     <= cnt_next;
      ddr_ready   <= (state_next == ACTIVE) && (cnt_next < CNT_W'(MAX_OUTSTANDING));
      ddr_wr_done <= acc_wr;
      err_q       <= acc_wr & (ddr_rd_req | ~in_range);
    end
  end

  // Byte-masked write; memory is deliberately not reset so preloads survive.
  always_ff @(posedge clk) begin
    if (acc_wr && in_range) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (ddr_wr_be[b]) mem[idx][b*8 +: 8] <= ddr_wr_data[b*8 +: 8];
      end
    end
  end

  ddr_rd_pipe #(
    .DEPTH  (RD_LATENCY),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (acc_rd),
    .in_err    (~in_range),
    .in_data   (rd_word),
    .out_valid (ddr_rd_valid),
    .out_err   (pipe_err),
    .out_data  (ddr_rd_data)
  );

  assign ddr_err   = err_q | pipe_err;
  assign dbg_state = state;

endmodule

// File: tb/tb_ddr_mem_responder.sv
// Self-checking bench for ddr_mem_responder with a time-based reference model.
module tb_ddr_mem_responder;
  import ddr_pkg::*;

  localparam int LAT       = 4;
  localparam int MAXO      = 4;
  localparam int RP        = 20;
  localparam int RC        = 8;
  localparam int MEM_WORDS = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        ddr_rd_req, ddr_wr_req;
  logic [15:0] ddr_addr;
  logic [31:0] ddr_wr_data;
  logic [3:0]  ddr_wr_be;
  logic        ddr_ready, ddr_rd_valid, ddr_wr_done, ddr_err;
  logic [31:0] ddr_rd_data;
  ddr_state_t  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ddr_mem_responder #(
    .MEM_WORDS       (MEM_WORDS),
    .RD_LATENCY      (LAT),
    .MAX_OUTSTANDING (MAXO),
    .REFRESH_PERIOD  (RP),
    .REFRESH_CYCLES  (RC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ddr_rd_req   (ddr_rd_req),
    .ddr_wr_req   (ddr_wr_req),
    .ddr_addr     (ddr_addr),
    .ddr_wr_data  (ddr_wr_data),
    .ddr_wr_be    (ddr_wr_be),
    .ddr_ready    (ddr_ready),
    .ddr_rd_valid (ddr_rd_valid),
    .ddr_rd_data  (ddr_rd_data),
    .ddr_wr_done  (ddr_wr_done),
    .ddr_err      (ddr_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem_m [MEM_WORDS];
  logic [31:0] exp_q[$];      // expected read data, in order
  int          due_q[$];      // edge index after which each return is visible
  bit          experr_q[$];   // expected err flag for each return
  int          n_edge;        // rising edges since reset was released
  bit          m_ready, m_wr_done, m_werr, m_in_reset, last_acc;
  logic        obs_valid, obs_ready, obs_err, obs_wr_done;
  logic [31:0] obs_data;
  int          rv_count, rf_returns, tries;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Refresh windows begin every RP edges (first one RP edges after reset) and last RC cycles.
  function automatic bit in_refresh(input int n);
    return (n >= RP) && ((n % RP) < RC);
  endfunction

  // Model update at a rising edge, using the request inputs held across it.
  task automatic model_edge();
    bit oor;
    int outs;
    last_acc  = 1'b0;
    m_wr_done = 1'b0;
    m_werr    = 1'b0;
    if (reset) begin
      m_in_reset = 1'b1;
      n_edge     = 0;
      m_ready    = 1'b0;
      exp_q.delete();
      due_q.delete();
      experr_q.delete();
    end else begin
      m_in_reset = 1'b0;
      n_edge++;
      oor = int'(ddr_addr) >= MEM_WORDS;
      if (m_ready && ddr_wr_req) begin
        last_acc  = 1'b1;
        m_wr_done = 1'b1;
        m_werr    = ddr_rd_req || oor;
        if (!oor)
          for (int b = 0; b < 4; b++)
            if (ddr_wr_be[b]) mem_m[ddr_addr[13:0]][b*8 +: 8] = ddr_wr_data[b*8 +: 8];
      end else if (m_ready && ddr_rd_req) begin
        last_acc = 1'b1;
        exp_q.push_back(oor ? 32'hDEADBEEF : mem_m[ddr_addr[13:0]]);
        due_q.push_back(n_edge + LAT - 1);
        experr_q.push_back(oor);
      end
      outs = 0;
      foreach (due_q[i]) if (due_q[i] >= n_edge) outs++;
      m_ready = !in_refresh(n_edge) && (outs < MAXO);
    end
  endtask

  // Compare DUT outputs against the model, mid-cycle.
  task automatic compare();
    bit due;
    bit e_err;
    obs_valid   = ddr_rd_valid;
    obs_ready   = ddr_ready;
    obs_err     = ddr_err;
    obs_wr_done = ddr_wr_done;
    obs_data    = ddr_rd_data;
    if (ddr_rd_valid === 1'b1) begin
      rv_count++;
      if (dbg_state == REFRESH) rf_returns++;
    end
    if (m_in_reset) begin
      chk("rst_ready", 32'(ddr_ready), 32'd0);
      chk("rst_rd_valid", 32'(ddr_rd_valid), 32'd0);
      chk("rst_rd_data", ddr_rd_data, 32'd0);
      chk("rst_wr_done", 32'(ddr_wr_done), 32'd0);
      chk("rst_err", 32'(ddr_err), 32'd0);
    end else begin
      due   = (due_q.size() > 0) && (due_q[0] == n_edge);
      e_err = m_werr;
      chk("ready", 32'(ddr_ready), 32'(m_ready));
      chk("rd_valid", 32'(ddr_rd_valid), 32'(due));
      chk("wr_done", 32'(ddr_wr_done), 32'(m_wr_done));
      chk("state", 32'(dbg_state), 32'(in_refresh(n_edge)));
      if (due) begin
        chk("rd_data", ddr_rd_data, exp_q.pop_front());
        e_err = e_err | experr_q.pop_front();
        void'(due_q.pop_front());
      end
      chk("err", 32'(ddr_err), 32'(e_err));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input logic rst);
    ddr_rd_req  = rd;
    ddr_wr_req  = wr;
    ddr_addr    = addr;
    ddr_wr_data = data;
    ddr_wr_be   = be;
    reset       = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'd0, 32'd0, 4'd0, 1'b0);
  endtask

  // Hold a request until the model says it was taken; bounded.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [31:0] data, input logic [3:0] be, output int n_try);
    n_try = 0;
    do begin
      cycle(rd, wr, addr, data, be, 1'b0);
      n_try++;
    end while (!last_acc && n_try < 64);
    if (!last_acc) chk("issue_accept", 32'd0, 32'd1);
  endtask

  task automatic read_at(input logic [15:0] addr);
    issue(1'b1, 1'b0, addr, 32'd0, 4'd0, tries);
  endtask

  task automatic write_at(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
    issue(1'b0, 1'b1, addr, data, be, tries);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [15:0] a;
    reset = 1'b1; ddr_rd_req = 1'b0; ddr_wr_req = 1'b0;
    ddr_addr = '0; ddr_wr_data = '0; ddr_wr_be = '0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'd0, 32'd0, 4'd0, 1'b1);
    idle(1);
    chk("ready_after_reset", 32'(obs_ready), 32'd1);

    // Preload a small working set plus the alias of the out-of-range address.
    for (int i = 0; i < 64; i++)
      write_at(16'(i), (i == 5) ? 32'h13 : (i == 10) ? 32'h0 : $urandom, 4'hF);
    write_at(16'd3616, 32'hCAFEF00D, 4'hF);
    idle(6);

    // Single read: visible on the fourth cycle counting the accept cycle.
    read_at(16'd5);
    idle(2);
    chk("t1_early", 32'(obs_valid), 32'd0);
    idle(1);
    chk("t1_valid", 32'(obs_valid), 32'd1);
    chk("t1_data", obs_data, 32'h00000013);
    chk("t1_err", 32'(obs_err), 32'd0);

    // Byte-enabled write followed by a read of the same word.
    write_at(16'd10, 32'hAABBCCDD, 4'b0101);
    chk("t2_wr_done", 32'(obs_wr_done), 32'd1);
    read_at(16'd10);
    idle(3);
    chk("t2_data", obs_data, 32'h00BB00DD);

    // Five back-to-back reads right after a refresh window closes.
    for (int i = 0; i < 3 * RP && (n_edge % RP) != RC; i++) idle(1);
    rv_count = 0;
    for (int i = 0; i < 4; i++) read_at(16'(i));
    chk("t3_ready_low", 32'(obs_ready), 32'd0);
    read_at(16'd4);
    chk("t3_fifth_tries", 32'(tries), 32'd2);
    idle(6);
    chk("t3_returns", 32'(rv_count), 32'd5);

    // Out-of-range read and write.
    read_at(16'd20000);
    idle(3);
    chk("t4_valid", 32'(obs_valid), 32'd1);
    chk("t4_data", obs_data, 32'hDEADBEEF);
    chk("t4_err", 32'(obs_err), 32'd1);
    write_at(16'd20000, 32'h12345678, 4'hF);
    chk("t4_wr_done", 32'(obs_wr_done), 32'd1);
    chk("t4_wr_err", 32'(obs_err), 32'd1);
    read_at(16'd3616);
    idle(3);
    chk("t4_alias", obs_data, 32'hCAFEF00D);

    // Continuous reads across refresh windows.
    rf_returns = 0;
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, 16'($urandom_range(0, 63)), 32'd0, 4'd0, 1'b0);
    idle(6);
    chk("t5_refresh_drain", 32'(rf_returns > 0), 32'd1);

    // Randomized mix, including illegal read+write and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 15) == 0) ? 16'd20000 : 16'($urandom_range(0, 63));
      cycle(r <= 3 || r == 7, r >= 4 && r <= 7, a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    idle(6);

    // Reset with reads in flight: flushed reads never return; memory survives.
    write_at(16'd5, 32'h00000013, 4'hF);
    idle(6);
    for (int i = 0; i < 3; i++) read_at(16'(i + 1));
    idle(2);
    cycle(1'b0, 1'b0, 16'd0, 32'd0, 4'd0, 1'b1);
    cycle(1'b0, 1'b0, 16'd0, 32'd0, 4'd0, 1'b1);
    rv_count = 0;
    idle(10);
    chk("t6_no_valid", 32'(rv_count), 32'd0);
    read_at(16'd5);
    idle(3);
    chk("t6_preload", obs_data, 32'h00000013);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
